ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port round-robin arbiter that shares the single-ported system RAM between two bus masters: port 0, normally the instruction fetch, and port 1, normally the load/store unit. Every port, master-facing and RAM-facing, uses the same valid/ready/error handshake as the RAM. The block sits between the core's memory ports and the RAM. It serialises accesses, keeps each granted master's request on the RAM until completion, and converts a hung transaction into a bus error through a watchdog.

## Interface
Parameters:
- TIMEOUT, 16, BUSY cycles allowed before a transaction is aborted with error. Legal range is TIMEOUT ≥ 2.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- m0_address  in  32  port 0 byte address.
- m0_wdata  in  32  port 0 write data.
- m0_wsel  in  4  port 0 byte write enables; 0000 means read.
- m0_valid  in  1  port 0 request.
- m0_rdata  out  32  port 0 read data; valid only while m0_ready=1.
- m0_ready  out  1  port 0 completion pulse.
- m0_error  out  1  port 0 error, qualified by m0_ready.
- m1_address, m1_wdata, m1_wsel, m1_valid, m1_rdata, m1_ready, m1_error: identical to the port 0 signals, for port 1.
- ram_address  out  32  address to RAM.
- ram_wdata  out  32  write data to RAM.
- ram_wsel  out  4  byte enables to RAM.
- ram_valid  out  1  request to RAM.
- ram_rdata  in  32  RAM read data.
- ram_ready  in  1  RAM completion pulse.
- ram_error  in  1  RAM error, qualified by ram_ready.

## Operation
- Registers:
  - state, IDLE or BUSY.
  - grant, 1 bit: index of the master currently granted.
  - last, 1 bit: index of the most recently served master.
  - wdog: BUSY cycle counter, width clog2(TIMEOUT)+1.
- Reset (rst_n=0 at an edge): state=IDLE, grant=0, last=1 (so port 0 wins the first tie), wdog=0. This applies even mid-transaction; any ram_ready arriving afterwards is ignored.
- IDLE:
  - Only m0_valid set → grant=0, go to BUSY.
  - Only m1_valid set → grant=1, go to BUSY.
  - Both set → grant = ~last, go to BUSY.
  - Neither set → stay in IDLE.
  - wdog is cleared.
- BUSY:
  - ram_address, ram_wdata and ram_wsel are muxed combinationally from master[grant].
  - ram_valid = m<grant>_valid.
  - wdog increments each cycle.
- BUSY, ram_ready=1: m<grant>_ready=1 and m<grant>_error=ram_error. Then last=grant and state goes to IDLE.
- BUSY, ram_ready=0 with wdog==TIMEOUT-1: this is a timeout. m<grant>_ready=1 and m<grant>_error=1. Then last=grant and state goes to IDLE.
- In IDLE, ram_valid=0. The address, data and wsel outputs then show master[grant] (don't-care). ram_ready and ram_error are ignored.
- m0_rdata and m1_rdata are both driven with ram_rdata (broadcast). The non-granted master always sees ready=0 and error=0.
- Masters hold valid and all request fields stable until their ready pulse. Writes commit in the RAM's ready cycle, so address, wsel and wdata must remain valid through it.
- The forced IDLE cycle after each completion deasserts ram_valid. This guarantees the RAM's ready drops before the next request starts.

## Timing
- All master- and RAM-facing outputs are combinational from state, grant, wdog and the inputs. There is no input-to-output path through IDLE: ram_valid=0 there.
- Request latency with the RAM's 1-cycle response:
  - Cycle 0: m_valid rises while the arbiter is in IDLE.
  - Cycle 1: BUSY, ram_valid=1.
  - Cycle 2: ram_ready=1 and m_ready=1.
  - Cycle 3: IDLE.
  - Cycle 4: earliest next grant.
- Throughput is one access per 3 cycles when requests are back-to-back.
- A request arriving in the same cycle as the other port's completion is seen in the following IDLE cycle.
- Timeout response appears in the TIMEOUT-th BUSY cycle, exactly TIMEOUT cycles after the grant edge.
- If ram_ready and the timeout condition coincide, ram_ready wins: error = ram_error.
- ready and error are single-cycle pulses, never asserted for both masters in the same cycle.

## Test plan
- Port 0 read only (m0_address=0x40, wsel=0, RAM preloaded 0xDEADBEEF at word 0x10) → m0_ready=1 with m0_rdata=0xDEADBEEF two cycles after valid. m1_ready stays 0 throughout.
- Both valid continuously after reset, port 0 reading and port 1 reading → grants alternate 0,1,0,1. Each port receives a ready every 6 cycles. The first ready goes to port 0.
- Port 1 write 0xAABBCCDD to 0x100 with wsel=0101, then port 0 reads 0x100 (RAM word preloaded 0) → read returns 0x00BB00DD. Both m_error values are 0.
- RAM stub that never asserts ready, TIMEOUT=4, port 0 request → m0_ready=1 and m0_error=1 exactly 4 cycles after the grant edge. The arbiter then returns to IDLE and serves a pending port 1 request normally.
- Reset pulse (rst_n=0 for one edge) during BUSY of port 1 → next cycle ram_valid=0 and there is no ready to either port. With both ports then valid, port 0 is granted first.
- RAM stub returning ram_error=1 with ready for port 1 → m1_ready=1 and m1_error=1 in the same cycle. m0_ready and m0_error stay 0.

Source files
------------

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-ported RAM between two valid/ready masters,
// with a BUSY watchdog that turns a hung RAM access into a bus error.
module ram_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] m0_address,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wsel,
  input  logic        m0_valid,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  output logic        m0_error,
  input  logic [31:0] m1_address,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wsel,
  input  logic        m1_valid,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        m1_error,
  output logic [31:0] ram_address,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_wsel,
  output logic        ram_valid,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ready,
  input  logic        ram_error
);

  localparam int WDOG_W = $clog2(TIMEOUT) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t              state;
  logic                grant;
  logic                last;
  logic [WDOG_W-1:0]   wdog;

  logic busy;
  logic timeout_hit;
  logic done;
  logic done_err;

  // NOTE: every output gets a value on every path through always_comb; a missing
  // default would infer a latch.
  always_comb begin
    busy        = (state == BUSY);
    timeout_hit = (wdog == WDOG_W'(TIMEOUT - 1));
    done        = busy && (ram_ready || timeout_hit);
    // A real RAM completion beats a coincident watchdog expiry.
    done_err    = ram_ready ? ram_error : 1'b1;

    ram_address = grant ? m1_address : m0_address;
    ram_wdata   = grant ? m1_wdata   : m0_wdata;
    ram_wsel    = grant ? m1_wsel    : m0_wsel;
    ram_valid   = busy && (grant ? m1_valid : m0_valid);

    m0_ready    = done && !grant;
    m1_ready    = done &&  grant;
    m0_error    = m0_ready && done_err;
    m1_error    = m1_ready && done_err;
  end

  assign m0_rdata = ram_rdata;
  assign m1_rdata = ram_rdata;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= 1'b0;
      last  <= 1'b1;
      wdog  <= '0;
    end else begin
      case (state)
        IDLE: begin
          wdog <= '0;
          if (m0_valid && m1_valid) begin
            grant <= ~last;
            state <= BUSY;
          end else if (m0_valid) begin
            grant <= 1'b0;
            state <= BUSY;
          end else if (m1_valid) begin
            grant <= 1'b1;
            state <= BUSY;
          end
        end
        BUSY: begin
          wdog <= wdog + WDOG_W'(1);
          // Always pass through IDLE so ram_valid drops between accesses.
          if (done) begin
            last  <= grant;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: per-port scoreboards fed by the request
// driver and drained by a monitor on each ready pulse, plus a configurable RAM stub.
module tb_ram_arbiter;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] m0_address, m0_wdata, m0_rdata;
  logic [3:0]  m0_wsel;
  logic        m0_valid, m0_ready, m0_error;
  logic [31:0] m1_address, m1_wdata, m1_rdata;
  logic [3:0]  m1_wsel;
  logic        m1_valid, m1_ready, m1_error;
  logic [31:0] ram_address, ram_wdata, ram_rdata;
  logic [3:0]  ram_wsel;
  logic        ram_valid;
  logic        ram_ready = 1'b0;
  logic        ram_error;

  always #5 clk = ~clk;

  ram_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_address(m0_address), .m0_wdata(m0_wdata), .m0_wsel(m0_wsel), .m0_valid(m0_valid),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_error(m0_error),
    .m1_address(m1_address), .m1_wdata(m1_wdata), .m1_wsel(m1_wsel), .m1_valid(m1_valid),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_error(m1_error),
    .ram_address(ram_address), .ram_wdata(ram_wdata), .ram_wsel(ram_wsel),
    .ram_valid(ram_valid), .ram_rdata(ram_rdata), .ram_ready(ram_ready), .ram_error(ram_error)
  );

  typedef struct {
    logic        chk_data;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  // RAM stub: ready after ram_lat cycles of valid, never while stalled.
  logic [31:0] mem [256];
  bit          stall    = 1'b0;
  bit          err_mode = 1'b0;
  int          ram_lat  = 1;
  int          lat_cnt  = 0;

  assign ram_rdata = mem[ram_address[9:2]];
  assign ram_error = ram_ready && err_mode;

  always @(posedge clk) begin
    if (ram_valid && ram_ready && ram_wsel != 4'b0000)
      for (int b = 0; b < 4; b++)
        if (ram_wsel[b]) mem[ram_address[9:2]][8*b +: 8] = ram_wdata[8*b +: 8];
    if (ram_valid && !ram_ready && !stall) begin
      if (lat_cnt >= ram_lat - 1) begin
        ram_ready <= 1'b1;
        lat_cnt   <= 0;
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end else begin
      ram_ready <= 1'b0;
      if (!ram_valid) lat_cnt <= 0;
    end
  end

  // NOTE: outputs are sampled on the falling edge, half a cycle away from the
  // rising edge where both DUT and stub update.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      checks++;
      if ((m0_ready && m1_ready) || (m0_error && !m0_ready) || (m1_error && !m1_ready)) begin
        errors++;
        $display("FAIL pulse_exclusive: m0 rdy/err=%b%b m1 rdy/err=%b%b, required one ready at most and error only with ready",
                 m0_ready, m0_error, m1_ready, m1_error);
      end
      if (m0_ready) begin
        checks++;
        if (sb0.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ready port 0: got ready, required none outstanding");
        end else begin
          e = sb0.pop_front();
          if (m0_error !== e.err || (e.chk_data && m0_rdata !== e.rdata)) begin
            errors++;
            $display("FAIL response port 0: got err=%b rdata=%h, required err=%b rdata=%h",
                     m0_error, m0_rdata, e.err, e.rdata);
          end
        end
      end
      if (m1_ready) begin
        checks++;
        if (sb1.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ready port 1: got ready, required none outstanding");
        end else begin
          e = sb1.pop_front();
          if (m1_error !== e.err || (e.chk_data && m1_rdata !== e.rdata)) begin
            errors++;
            $display("FAIL response port 1: got err=%b rdata=%h, required err=%b rdata=%h",
                     m1_error, m1_rdata, e.err, e.rdata);
          end
        end
      end
    end
  end

  // Presents one request on port p, holds it until its ready, checks latency.
  task automatic do_req(input bit p, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wsel, input logic chk_data,
                        input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    exp_t e;
    bit   got;
    int   lat;
    @(posedge clk); #1;
    e.chk_data = chk_data;
    e.rdata    = exp_rdata;
    e.err      = exp_err;
    if (!p) begin
      m0_address = addr; m0_wdata = wdata; m0_wsel = wsel; m0_valid = 1'b1;
      sb0.push_back(e);
    end else begin
      m1_address = addr; m1_wdata = wdata; m1_wsel = wsel; m1_valid = 1'b1;
      sb1.push_back(e);
    end
    got = 1'b0;
    lat = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if ((!p && m0_ready) || (p && m1_ready)) begin
        got = 1'b1;
        lat = k;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ready_wait port %0d: no ready within 40 cycles, required one after %0d", p, exp_lat);
      if (p) sb1.delete(); else sb0.delete();
    end else if (lat != exp_lat) begin
      errors++;
      $display("FAIL latency port %0d: got %0d cycles, required %0d", p, lat, exp_lat);
    end
    @(posedge clk); #1;
    if (!p) m0_valid = 1'b0; else m1_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m0_address = '0; m0_wdata = '0; m0_wsel = '0; m0_valid = 1'b0;
    m1_address = '0; m1_wdata = '0; m1_wsel = '0; m1_valid = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ram_valid, m0_ready, m0_error, m1_ready, m1_error} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got ram_valid,m0 rdy/err,m1 rdy/err=%b, required 00000",
               {ram_valid, m0_ready, m0_error, m1_ready, m1_error});
    end
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_port0_read();
    mem[8'h10] = 32'hDEADBEEF;
    fork
      do_req(1'b0, 32'h40, 32'h0, 4'b0000, 1'b1, 32'hDEADBEEF, 1'b0, 2);
      begin
        @(posedge clk); @(posedge clk); @(negedge clk);
        checks++;
        if (ram_valid !== 1'b1 || ram_address !== 32'h40 || ram_wsel !== 4'b0000) begin
          errors++;
          $display("FAIL busy_mux: got valid=%b addr=%h wsel=%b, required valid=1 addr=00000040 wsel=0000",
                   ram_valid, ram_address, ram_wsel);
        end
      end
    join
    @(negedge clk);
    checks++;
    if (ram_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid: got ram_valid=%b, required 0 after completion", ram_valid);
    end
  endtask

  task automatic test_alternate();
    int         t[4];
    int         pt[4];
    int         n;
    exp_t       e0, e1;
    int         exp_t_tab[4];
    int         exp_p_tab[4];
    exp_t_tab = '{2, 5, 8, 11};
    exp_p_tab = '{0, 1, 0, 1};
    mem[8'h40] = 32'h12345678;
    e0 = '{chk_data: 1'b1, rdata: 32'hDEADBEEF, err: 1'b0};
    e1 = '{chk_data: 1'b1, rdata: 32'h12345678, err: 1'b0};
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m0_address = 32'h40;  m0_wsel = 4'b0000; m0_valid = 1'b1;
    m1_address = 32'h100; m1_wsel = 4'b0000; m1_valid = 1'b1;
    sb0.push_back(e0); sb0.push_back(e0);
    sb1.push_back(e1); sb1.push_back(e1);
    n = 0;
    for (int i = 0; i < 4; i++) begin t[i] = -1; pt[i] = -1; end
    for (int k = 0; k < 30 && n < 4; k++) begin
      @(negedge clk);
      if (m0_ready) begin t[n] = k; pt[n] = 0; n++; end
      else if (m1_ready) begin t[n] = k; pt[n] = 1; n++; end
    end
    @(posedge clk); #1;
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (t[i] != exp_t_tab[i] || pt[i] != exp_p_tab[i]) begin
        errors++;
        $display("FAIL alternate[%0d]: got port %0d at cycle %0d, required port %0d at cycle %0d",
                 i, pt[i], t[i], exp_p_tab[i], exp_t_tab[i]);
      end
    end
  endtask

  task automatic test_write_read();
    mem[8'h40] = 32'h0;
    do_req(1'b1, 32'h100, 32'hAABBCCDD, 4'b0101, 1'b0, 32'h0, 1'b0, 2);
    do_req(1'b0, 32'h100, 32'h0, 4'b0000, 1'b1, 32'h00BB00DD, 1'b0, 2);
  endtask

  task automatic test_timeout();
    stall = 1'b1;
    fork
      do_req(1'b0, 32'h40, 32'h0, 4'b0000, 1'b0, 32'h0, 1'b1, TIMEOUT);
      begin
        @(posedge clk);
        do_req(1'b1, 32'h40, 32'h0, 4'b0000, 1'b1, 32'hDEADBEEF, 1'b0, TIMEOUT + 2);
      end
      begin
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          if (m0_ready) break;
        end
        @(posedge clk); #1;
        stall = 1'b0;
      end
    join
  endtask

  task automatic test_ready_vs_timeout();
    // RAM answers in the watchdog's last cycle: the RAM's answer wins.
    ram_lat = TIMEOUT - 1;
    do_req(1'b0, 32'h40, 32'h0, 4'b0000, 1'b1, 32'hDEADBEEF, 1'b0, TIMEOUT);
    // RAM answers one cycle too late: timeout error, and the late ready is ignored.
    ram_lat = TIMEOUT;
    do_req(1'b1, 32'h40, 32'h0, 4'b0000, 1'b0, 32'h0, 1'b1, TIMEOUT);
    repeat (2) @(posedge clk);
    ram_lat = 1;
    do_req(1'b0, 32'h40, 32'h0, 4'b0000, 1'b1, 32'hDEADBEEF, 1'b0, 2);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    m1_address = 32'h40; m1_wsel = 4'b0000; m1_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (ram_valid !== 1'b1 || ram_address !== 32'h40) begin
      errors++;
      $display("FAIL busy_port1: got valid=%b addr=%h, required valid=1 addr=00000040", ram_valid, ram_address);
    end
    rst_n    = 1'b0;
    m1_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({ram_valid, m0_ready, m1_ready} !== 3'b000) begin
      errors++;
      $display("FAIL reset_abort: got ram_valid,m0_ready,m1_ready=%b, required 000",
               {ram_valid, m0_ready, m1_ready});
    end
    fork
      do_req(1'b0, 32'h40, 32'h0, 4'b0000, 1'b1, 32'hDEADBEEF, 1'b0, 2);
      do_req(1'b1, 32'h40, 32'h0, 4'b0000, 1'b1, 32'hDEADBEEF, 1'b0, 5);
    join
  endtask

  task automatic test_ram_error();
    err_mode = 1'b1;
    do_req(1'b1, 32'h40, 32'h0, 4'b0000, 1'b0, 32'h0, 1'b1, 2);
    err_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_port0_read();
    test_alternate();
    test_write_read();
    test_timeout();
    test_ready_vs_timeout();
    test_reset_mid();
    test_ram_error();
    repeat (3) @(posedge clk);
    checks++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d responses outstanding, required 0/0", sb0.size(), sb1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete within 100000 time units");
    $fatal(1, "bench time limit exceeded");
  end

endmodule
